commit_controller: RTL and testbench

- Sequences in-order retirement from the ROB head into register_file, the store path and the fetcher.
- Decides each cycle whether the head commits, waits for a store to drain, or triggers a misbranch flush.
- Generates the register file's commit and rollback inputs (commit_flag, rd, Q, V, rollback_flag).
- Sits between the ROB and register_file, the LSB and the fetcher.

---
 rtl/commit_controller_pkg.sv | 26 ++
 rtl/commit_controller_perf_counter.sv | 34 +++
 rtl/commit_controller.sv | 177 +++++++++++++++++
 tb/tb_commit_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_controller_pkg.sv
// Shared constants for the commit controller: default widths, zero values,
// boolean literals and the controller state encoding.
package commit_controller_pkg;

  // Default widths (bits)
  localparam int ROB_ID_TYPE  = 4;
  localparam int REG_POS_TYPE = 5;
  localparam int DATA_TYPE    = 32;
  localparam int ADDR_TYPE    = 32;

  // Zero values; ROB tag 0 means "no producer"
  localparam logic [ROB_ID_TYPE-1:0]  ZERO_ROB  = '0;
  localparam logic [REG_POS_TYPE-1:0] ZERO_REG  = '0;
  localparam logic [DATA_TYPE-1:0]    ZERO_WORD = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Controller states
  typedef enum logic [1:0] {
    CC_IDLE       = 2'd0,
    CC_WAIT_STORE = 2'd1,
    CC_FLUSH      = 2'd2
  } cc_state_e;

endpackage

// File: rtl/commit_controller_perf_counter.sv
// Commit and mispredict event counters. Both wrap modulo 2^32.
// Only instantiated when COMMIT_PERF_EN is defined.
module commit_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_commit,
  input  logic        i_rollback,
  output logic [31:0] o_commit_count,
  output logic [31:0] o_mispredict_count
);

  logic [1:0]  w_inc;
  logic [31:0] r_count [2];

  assign w_inc = {i_rollback, i_commit};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // One free-running event counter per tracked event
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count[gi] <= '0;
        end else if (w_inc[gi]) begin
          r_count[gi] <= r_count[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign o_commit_count     = r_count[0];
  assign o_mispredict_count = r_count[1];

endmodule

// File: rtl/commit_controller.sv
// In-order retirement sequencer between the ROB head, register_file, the LSB
// store path and the fetcher. Commits ready heads one per cycle, hands stores
// to the LSB and waits for completion, and raises a rollback/jump on a
// mispredicted head followed by FLUSH_CYCLES dead cycles (FLUSH_CYCLES >= 1).
// Optional macro COMMIT_PERF_EN adds commit_count / mispredict_count ports.
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_ID_WIDTH  = ROB_ID_TYPE,
  parameter int REG_POS_WIDTH = REG_POS_TYPE,
  parameter int DATA_WIDTH    = DATA_TYPE,
  parameter int ADDR_WIDTH    = ADDR_TYPE,
  parameter int FLUSH_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     head_valid,
  input  logic                     head_ready,
  input  logic [ROB_ID_WIDTH-1:0]  head_rob_id,
  input  logic [REG_POS_WIDTH-1:0] head_rd,
  input  logic [DATA_WIDTH-1:0]    head_value,
  input  logic                     head_is_store,
  input  logic                     head_mispredict,
  input  logic [ADDR_WIDTH-1:0]    head_target_pc,
  output logic                     rob_pop,
  output logic                     store_commit_req,
  input  logic                     store_done,
  output logic                     commit_flag,
  output logic [REG_POS_WIDTH-1:0] rd_to_reg,
  output logic [ROB_ID_WIDTH-1:0]  Q_to_reg,
  output logic [DATA_WIDTH-1:0]    V_to_reg,
  output logic                     rollback_flag,
  output logic                     jump_flag,
  output logic [ADDR_WIDTH-1:0]    jump_pc
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0]              commit_count,
  output logic [31:0]              mispredict_count
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  cc_state_e                r_state, w_state_next;
  logic [CNT_W-1:0]         r_flush_cnt, w_flush_cnt_next;
  logic                     r_store_req, w_store_req_next;
  logic                     r_commit, w_commit_next;
  logic [REG_POS_WIDTH-1:0] r_rd, w_rd_next;
  logic [ROB_ID_WIDTH-1:0]  r_q, w_q_next;
  logic [DATA_WIDTH-1:0]    r_v, w_v_next;
  logic                     r_rollback, w_rollback_next;
  logic                     r_jump, w_jump_next;
  logic [ADDR_WIDTH-1:0]    r_jump_pc, w_jump_pc_next;
  logic                     w_pop;
  logic                     w_head_go;

  assign w_head_go = head_valid & head_ready;

  // Next-state and next-output decode; everything holds unless rdy and the
  // current state says otherwise, and pulses default low so they never repeat
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_store_req_next = r_store_req;
    w_commit_next    = FALSE;
    w_rd_next        = r_rd;
    w_q_next         = r_q;
    w_v_next         = r_v;
    w_rollback_next  = FALSE;
    w_jump_next      = FALSE;
    w_jump_pc_next   = r_jump_pc;
    w_pop            = FALSE;
    if (rdy) begin
      case (r_state)
        CC_IDLE: begin
          if (w_head_go) begin
            if (head_is_store) begin
              // Stores retire only after the LSB confirms the write
              w_store_req_next = TRUE;
              w_state_next     = CC_WAIT_STORE;
            end else begin
              w_pop         = TRUE;
              w_commit_next = TRUE;
              w_rd_next     = head_rd;
              w_q_next      = head_rob_id;
              w_v_next      = head_value;
              if (head_mispredict) begin
                w_rollback_next  = TRUE;
                w_jump_next      = TRUE;
                w_jump_pc_next   = head_target_pc;
                w_flush_cnt_next = CNT_W'(FLUSH_CYCLES);
                w_state_next     = CC_FLUSH;
              end
            end
          end
        end
        CC_WAIT_STORE: begin
          if (store_done) begin
            w_pop            = TRUE;
            w_store_req_next = FALSE;
            w_state_next     = CC_IDLE;
          end
        end
        CC_FLUSH: begin
          // ROB content is stale here; count down dead cycles
          if (r_flush_cnt <= CNT_W'(1)) begin
            w_flush_cnt_next = '0;
            w_state_next     = CC_IDLE;
          end else begin
            w_flush_cnt_next = r_flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_next     = CC_IDLE;
          w_flush_cnt_next = '0;
        end
      endcase
    end
  end

  // State and flush counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CC_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Registered outputs to register_file, LSB and fetcher
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store_req <= FALSE;
      r_commit    <= FALSE;
      r_rd        <= REG_POS_WIDTH'(ZERO_REG);
      r_q         <= ROB_ID_WIDTH'(ZERO_ROB);
      r_v         <= DATA_WIDTH'(ZERO_WORD);
      r_rollback  <= FALSE;
      r_jump      <= FALSE;
      r_jump_pc   <= '0;
    end else begin
      r_store_req <= w_store_req_next;
      r_commit    <= w_commit_next;
      r_rd        <= w_rd_next;
      r_q         <= w_q_next;
      r_v         <= w_v_next;
      r_rollback  <= w_rollback_next;
      r_jump      <= w_jump_next;
      r_jump_pc   <= w_jump_pc_next;
    end
  end

  assign rob_pop          = w_pop & ~rst;
  assign store_commit_req = r_store_req;
  assign commit_flag      = r_commit;
  assign rd_to_reg        = r_rd;
  assign Q_to_reg         = r_q;
  assign V_to_reg         = r_v;
  assign rollback_flag    = r_rollback;
  assign jump_flag        = r_jump;
  assign jump_pc          = r_jump_pc;

`ifdef COMMIT_PERF_EN
  commit_perf_counter u_perf (
    .clk                (clk),
    .rst                (rst),
    .i_commit           (rob_pop),
    .i_rollback         (w_rollback_next),
    .o_commit_count     (commit_count),
    .o_mispredict_count (mispredict_count)
  );
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Bench for commit_controller: directed vector table, randomized run against a
// behavioural model, and an asynchronous reset during a pending store.
module tb_commit_controller;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy, head_valid, head_ready, head_is_store, head_mispredict, store_done;
  logic [3:0]  head_rob_id;
  logic [4:0]  head_rd;
  logic [31:0] head_value, head_target_pc;
  logic        rob_pop, store_commit_req, commit_flag, rollback_flag, jump_flag;
  logic [4:0]  rd_to_reg;
  logic [3:0]  Q_to_reg;
  logic [31:0] V_to_reg, jump_pc;
`ifdef COMMIT_PERF_EN
  logic [31:0] commit_count, mispredict_count;
`endif

  commit_controller #(
    .ROB_ID_WIDTH(4), .REG_POS_WIDTH(5), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .head_valid(head_valid), .head_ready(head_ready), .head_rob_id(head_rob_id),
    .head_rd(head_rd), .head_value(head_value), .head_is_store(head_is_store),
    .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
    .rob_pop(rob_pop), .store_commit_req(store_commit_req), .store_done(store_done),
    .commit_flag(commit_flag), .rd_to_reg(rd_to_reg), .Q_to_reg(Q_to_reg),
    .V_to_reg(V_to_reg), .rollback_flag(rollback_flag), .jump_flag(jump_flag),
    .jump_pc(jump_pc)
`ifdef COMMIT_PERF_EN
    , .commit_count(commit_count), .mispredict_count(mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rdy, hv, hr;
    logic [3:0] id;
    logic [4:0] rd;
    logic [31:0] v;
    logic st, mp;
    logic [31:0] tpc;
    logic sd;
  } in_t;

  typedef struct {
    logic pop, cf;
    logic [4:0] rd;
    logic [3:0] q;
    logic [31:0] v;
    logic rb, jf;
    logic [31:0] jpc;
    logic scr;
  } exp_t;

  typedef struct { in_t i; exp_t e; } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_trans  = 0;

  // Reference model: registered outputs plus "store outstanding" and
  // "dead cycles remaining" bookkeeping
  exp_t        m_out;
  bit          m_store_pending;
  int          m_flush_left;
  logic [31:0] m_cc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_out = '{pop:0, cf:0, rd:0, q:0, v:0, rb:0, jf:0, jpc:0, scr:0};
    m_store_pending = 0;
    m_flush_left = 0;
    m_cc = 0;
    m_mc = 0;
  endfunction

  function automatic exp_t model_step(input in_t x);
    exp_t e = m_out;
    e.pop = 0; e.cf = 0; e.rb = 0; e.jf = 0;
    if (x.rdy) begin
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_store_pending) begin
        if (x.sd) begin
          e.pop = 1; e.scr = 0; m_store_pending = 0;
        end
      end else if (x.hv && x.hr) begin
        if (x.st) begin
          e.scr = 1; m_store_pending = 1;
        end else begin
          e.pop = 1; e.cf = 1; e.rd = x.rd; e.q = x.id; e.v = x.v;
          if (x.mp) begin
            e.rb = 1; e.jf = 1; e.jpc = x.tpc; m_flush_left = FLUSH;
          end
        end
      end
    end
    m_out = e;
    m_cc = m_cc + {31'd0, e.pop};
    m_mc = m_mc + {31'd0, e.rb};
    return e;
  endfunction

  task automatic drive(input in_t x);
    rdy = x.rdy; head_valid = x.hv; head_ready = x.hr; head_rob_id = x.id;
    head_rd = x.rd; head_value = x.v; head_is_store = x.st; head_mispredict = x.mp;
    head_target_pc = x.tpc; store_done = x.sd;
  endtask

  // One transaction: drive at negedge, check rob_pop before the edge and the
  // registered outputs just after it
  task automatic run_vec(input in_t x, input exp_t e, input string tag);
    @(negedge clk);
    drive(x);
    #1;
    chk({tag, ".rob_pop"}, rob_pop, e.pop);
    @(posedge clk);
    #1;
    chk({tag, ".commit_flag"}, commit_flag, e.cf);
    chk({tag, ".rd"}, rd_to_reg, e.rd);
    chk({tag, ".Q"}, Q_to_reg, e.q);
    chk({tag, ".V"}, V_to_reg, e.v);
    chk({tag, ".rollback"}, rollback_flag, e.rb);
    chk({tag, ".jump_flag"}, jump_flag, e.jf);
    chk({tag, ".jump_pc"}, jump_pc, e.jpc);
    chk({tag, ".store_req"}, store_commit_req, e.scr);
`ifdef COMMIT_PERF_EN
    chk({tag, ".commit_count"}, commit_count, m_cc);
    chk({tag, ".mispredict_count"}, mispredict_count, m_mc);
`endif
    $display("T%0d %s pop=%0b cf=%0b rd=%0d q=%0d v=%h rb=%0b jf=%0b jpc=%h scr=%0b",
             n_trans, tag, e.pop, commit_flag, rd_to_reg, Q_to_reg, V_to_reg,
             rollback_flag, jump_flag, jump_pc, store_commit_req);
    n_trans++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rob_pop"}, rob_pop, 0);
    chk({tag, ".commit_flag"}, commit_flag, 0);
    chk({tag, ".rd"}, rd_to_reg, 0);
    chk({tag, ".Q"}, Q_to_reg, 0);
    chk({tag, ".V"}, V_to_reg, 0);
    chk({tag, ".rollback"}, rollback_flag, 0);
    chk({tag, ".jump_flag"}, jump_flag, 0);
    chk({tag, ".jump_pc"}, jump_pc, 0);
    chk({tag, ".store_req"}, store_commit_req, 0);
`ifdef COMMIT_PERF_EN
    chk({tag, ".commit_count"}, commit_count, 0);
    chk({tag, ".mispredict_count"}, mispredict_count, 0);
`endif
  endtask

  task automatic do_reset();
    drive('{rdy:1, hv:0, hr:0, id:0, rd:0, v:0, st:0, mp:0, tpc:0, sd:0});
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mkv(
      input logic rdy, hv, hr, input logic [3:0] id, input logic [4:0] rd,
      input logic [31:0] v, input logic st, mp, input logic [31:0] tpc, input logic sd,
      input logic pop, cf, input logic [4:0] erd, input logic [3:0] eq,
      input logic [31:0] ev, input logic rb, jf, input logic [31:0] jpc, input logic scr);
    vec_t r;
    r.i = '{rdy:rdy, hv:hv, hr:hr, id:id, rd:rd, v:v, st:st, mp:mp, tpc:tpc, sd:sd};
    r.e = '{pop:pop, cf:cf, rd:erd, q:eq, v:ev, rb:rb, jf:jf, jpc:jpc, scr:scr};
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    exp_t ex;
    in_t  x;

    // Directed vectors (FLUSH_CYCLES = 2)
    tbl.push_back(mkv(1,1,1, 3, 5,32'hDEADBEEF,0,0,0,0, 1,1, 5, 3,32'hDEADBEEF,0,0,0,0));
    tbl.push_back(mkv(1,0,1, 3, 5,32'hDEADBEEF,0,0,0,0, 0,0, 5, 3,32'hDEADBEEF,0,0,0,0));
    tbl.push_back(mkv(1,1,1, 4, 1,32'h11,0,0,0,0,       1,1, 1, 4,32'h11,0,0,0,0));
    tbl.push_back(mkv(1,1,1, 5, 2,32'h22,0,0,0,0,       1,1, 2, 5,32'h22,0,0,0,0));
    tbl.push_back(mkv(1,1,1, 6, 3,32'h33,0,0,0,0,       1,1, 3, 6,32'h33,0,0,0,0));
    tbl.push_back(mkv(1,1,1, 7, 0,32'h77,1,0,0,0,       0,0, 3, 6,32'h33,0,0,0,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(1,1,1, 8, 9,32'h99,0,0,0,0,     0,0, 3, 6,32'h33,0,0,0,1));
    tbl.push_back(mkv(1,1,1, 8, 9,32'h99,0,0,0,1,       1,0, 3, 6,32'h33,0,0,0,0));
    tbl.push_back(mkv(1,1,1, 8, 9,32'h99,0,1,32'h1000,0, 1,1, 9, 8,32'h99,1,1,32'h1000,0));
    tbl.push_back(mkv(1,1,1, 9,10,32'hAA,0,0,0,0,       0,0, 9, 8,32'h99,0,0,32'h1000,0));
    tbl.push_back(mkv(1,1,1, 9,10,32'hAA,0,0,0,0,       0,0, 9, 8,32'h99,0,0,32'h1000,0));
    tbl.push_back(mkv(1,1,1, 9,10,32'hAA,0,0,0,0,       1,1,10, 9,32'hAA,0,0,32'h1000,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(0,1,1,10,11,32'hBB,0,0,0,0,     0,0,10, 9,32'hAA,0,0,32'h1000,0));
    tbl.push_back(mkv(1,1,1,10,11,32'hBB,0,0,0,0,       1,1,11,10,32'hBB,0,0,32'h1000,0));
    tbl.push_back(mkv(1,1,1,11, 0,32'h5,0,0,0,0,        1,1, 0,11,32'h5,0,0,32'h1000,0));
    tbl.push_back(mkv(1,1,0,12, 4,32'h66,0,0,0,0,       0,0, 0,11,32'h5,0,0,32'h1000,0));
    tbl.push_back(mkv(1,1,1,12, 6,32'h12345678,0,1,32'h2000,0, 1,1,6,12,32'h12345678,1,1,32'h2000,0));
    tbl.push_back(mkv(0,1,1,13, 7,32'h1,0,0,0,0,        0,0, 6,12,32'h12345678,0,0,32'h2000,0));
    tbl.push_back(mkv(1,1,1,13, 7,32'h1,0,0,0,0,        0,0, 6,12,32'h12345678,0,0,32'h2000,0));
    tbl.push_back(mkv(1,1,1,13, 7,32'h1,0,0,0,0,        0,0, 6,12,32'h12345678,0,0,32'h2000,0));
    tbl.push_back(mkv(1,1,1,13, 7,32'h1,0,0,0,0,        1,1, 7,13,32'h1,0,0,32'h2000,0));

    do_reset();
    foreach (tbl[k]) begin
      void'(model_step(tbl[k].i));
      run_vec(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      x.rdy = ($urandom_range(0, 5) != 0);
      x.hv  = ($urandom_range(0, 4) != 0);
      x.hr  = ($urandom_range(0, 3) != 0);
      x.id  = 4'($urandom);
      x.rd  = 5'($urandom);
      x.v   = $urandom;
      x.st  = ($urandom_range(0, 4) == 0);
      x.mp  = !x.st && ($urandom_range(0, 7) == 0);
      x.tpc = $urandom;
      x.sd  = ($urandom_range(0, 2) == 0);
      ex = model_step(x);
      run_vec(x, ex, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset while a store is outstanding
    do_reset();
    x = '{rdy:1, hv:1, hr:1, id:2, rd:3, v:32'h44, st:1, mp:0, tpc:0, sd:0};
    ex = model_step(x);
    run_vec(x, ex, "ars_store");
    x.st = 0;
    ex = model_step(x);
    run_vec(x, ex, "ars_wait");
    @(negedge clk);
    x.sd = 1;
    drive(x);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("ars_async");
    @(posedge clk);
    #1;
    chk_all_zero("ars_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    x = '{rdy:1, hv:1, hr:1, id:5, rd:7, v:32'hCAFE, st:0, mp:0, tpc:0, sd:0};
    ex = model_step(x);
    run_vec(x, ex, "ars_idle_commit");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
